misao_mem_responder: RTL

- Synthesizable responder for the misao core's byte memory port (the core is the initiator).
- Serves core reads combinationally in the same cycle and commits core writes on the clock edge.
- Also owns program loading: after reset it holds the core in reset, fills RAM from a byte-stream load port, then releases the core.
- Sits between misao and the board-level loader; it replaces the behavioural memory used on the benches.

---
 rtl/misao_mem_pkg.sv | 13 +
 rtl/misao_mem_array.sv | 27 ++
 rtl/misao_mem_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/misao_mem_pkg.sv
// Shared types and widths for the misao byte-memory responder.
package misao_mem_pkg;

  localparam int unsigned MISAO_ADDR_W = 15;
  localparam int unsigned MISAO_DATA_W = 8;

  typedef enum logic [1:0] {
    StLoad,
    StHold,
    StRun
  } misao_state_e;

endpackage

// File: rtl/misao_mem_array.sv
// Byte RAM behind misao_mem_responder: combinational read port, single synchronous write port.
// Contents have no reset; the write source is selected by the responder.
module misao_mem_array
  import misao_mem_pkg::*;
#(
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AddrW-1:0]        waddr,
  input  logic [MISAO_DATA_W-1:0] wdata,
  input  logic [AddrW-1:0]        raddr,
  output logic [MISAO_DATA_W-1:0] rdata
);

  logic [MISAO_DATA_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/misao_mem_responder.sv
// Memory responder for the misao core: loads the program image, holds the core in reset,
// then serves core reads/writes. Optional feature: MISAO_MEM_WRITE_PROTECT_EN (err_wp port).
module misao_mem_responder
  import misao_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned LOAD_MAX    = 256,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [7:0]              load_data,
  input  logic                    load_last,
  output logic                    load_ready,
  output logic                    load_done,
  output logic                    core_rst,
  input  logic                    mem_enable_read,
  input  logic                    mem_enable_write,
  input  logic [MISAO_ADDR_W-1:0] mem_addr,
  input  logic                    mem_rw,
  input  logic [MISAO_DATA_W-1:0] mem_data_out,
  output logic [MISAO_DATA_W-1:0] mem_data_in,
  output logic                    err_oob
`ifdef MISAO_MEM_WRITE_PROTECT_EN
  ,
  output logic                    err_wp
`endif
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CW = $clog2(LOAD_MAX + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  if (LOAD_MAX > MEM_DEPTH) begin : g_bad_load_max
    $error("misao_mem_responder: LOAD_MAX must not exceed MEM_DEPTH");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("misao_mem_responder: HOLD_CYCLES must be at least 1");
  end

  misao_state_e state_q;
  logic [CW-1:0] load_cnt_q;
  logic [HW-1:0] hold_cnt_q;
  logic          core_rst_q, load_done_q, err_oob_q;

  logic                    run, in_range, load_accept, core_we, oob_hit;
  logic                    ram_we;
  logic [AW-1:0]           ram_waddr;
  logic [MISAO_DATA_W-1:0] ram_wdata, ram_rdata;

  // Direction flag is informational; the strobes decide.
  logic unused_rw;
  assign unused_rw = mem_rw;

  assign run         = (state_q == StRun);
  assign in_range    = 32'(mem_addr) < MEM_DEPTH;
  assign load_ready  = rst && (state_q == StLoad);
  assign load_accept = load_ready && load_valid;
  assign oob_hit     = run && (mem_enable_read || mem_enable_write) && !in_range;

`ifdef MISAO_MEM_WRITE_PROTECT_EN
  logic err_wp_q, in_image, wp_hit;
  assign in_image = 32'(mem_addr) < 32'(load_cnt_q);
  assign wp_hit   = run && mem_enable_write && in_range && in_image;
  assign core_we  = run && mem_enable_write && in_range && !in_image;
  assign err_wp   = err_wp_q;
`else
  assign core_we  = run && mem_enable_write && in_range;
`endif

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (load_accept) begin
      ram_we    = 1'b1;
      ram_waddr = AW'(load_cnt_q);
      ram_wdata = load_data;
    end else if (core_we) begin
      ram_we    = 1'b1;
      ram_waddr = AW'(mem_addr);
      ram_wdata = mem_data_out;
    end
  end

  misao_mem_array #(
    .Depth (MEM_DEPTH),
    .AddrW (AW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (AW'(mem_addr)),
    .rdata (ram_rdata)
  );

  assign mem_data_in = (run && mem_enable_read && in_range) ? ram_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StLoad;
      load_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      core_rst_q  <= 1'b1;
      load_done_q <= 1'b0;
      err_oob_q   <= 1'b0;
`ifdef MISAO_MEM_WRITE_PROTECT_EN
      err_wp_q    <= 1'b0;
`endif
    end else begin
      if (oob_hit) err_oob_q <= 1'b1;
`ifdef MISAO_MEM_WRITE_PROTECT_EN
      if (wp_hit) err_wp_q <= 1'b1;
`endif
      case (state_q)
        StLoad: begin
          if (load_accept) begin
            load_cnt_q <= load_cnt_q + 1'b1;
            if (load_last || load_cnt_q == CW'(LOAD_MAX - 1)) state_q <= StHold;
          end
        end
        StHold: begin
          // core_rst drops on the edge after the counter reaches HOLD_CYCLES.
          if (hold_cnt_q == HW'(HOLD_CYCLES)) begin
            state_q     <= StRun;
            core_rst_q  <= 1'b0;
            load_done_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        StRun:   ;
        default: state_q <= StLoad;
      endcase
    end
  end

  assign core_rst  = core_rst_q;
  assign load_done = load_done_q;
  assign err_oob   = err_oob_q;

endmodule
